// File: rtl/prepare_scanline.sv
`default_nettype none
// ============================================================================
// Module  : prepare_scanline
// Purpose : Per-scanline sprite evaluator. When the scanline changes, OAM is
//           scanned once. The OAM addresses of the first maxObjectPerLine
//           objects whose vertical span covers the latched line are packed
//           into BufferArray as {index, valid}.
// Ports   : clk            - rising-edge clock
//           reset          - asynchronous, active-low reset
//           oam_data[31:0] - OAM word for the address driven last cycle
//                            ([9:0] y, [19:10] x, [31:20] attributes)
//           sx[9:0]        - current pixel x (not used for selection)
//           sy[9:0]        - current scanline
//           oam_addr       - OAM read address
//           BufferArray    - entry j = {oam index, valid}, valid is bit 0
//           line_prepeared - buffer complete and stable for latched line
// Revision: 1.0 - initial release
// ============================================================================
module prepare_scanline #(
  parameter int maxObjectPerLine = 32,
  parameter int OAMMaxObjects    = 256,
  parameter int OAM_ADDR_SIZE    = 6,
  parameter int OBJ_HEIGHT       = 16
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [31:0]                                      oam_data,
  input  logic [9:0]                                       sx,
  input  logic [9:0]                                       sy,
  output logic [OAM_ADDR_SIZE-1:0]                         oam_addr,
  output logic [maxObjectPerLine-1:0][OAM_ADDR_SIZE:0]     BufferArray,
  output logic                                             line_prepeared
);

  localparam int ADDR_SPAN = 1 << OAM_ADDR_SIZE;
  localparam int NUM_OBJ   = (OAMMaxObjects < ADDR_SPAN) ? OAMMaxObjects : ADDR_SPAN;
  localparam int CNT_W     = $clog2(maxObjectPerLine + 1);

  localparam logic [OAM_ADDR_SIZE-1:0] LAST_ADDR = OAM_ADDR_SIZE'(NUM_OBJ - 1);
  localparam logic [CNT_W-1:0]         LAST_SLOT = CNT_W'(maxObjectPerLine - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [OAM_ADDR_SIZE-1:0] ADDR_ONE  = OAM_ADDR_SIZE'(1);
  localparam logic [10:0]              HEIGHT    = 11'(OBJ_HEIGHT);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef logic [maxObjectPerLine-1:0][OAM_ADDR_SIZE:0] buf_t;

  state_t                   state_q, state_d;
  logic [9:0]               line_q, line_d;
  logic [OAM_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [OAM_ADDR_SIZE-1:0] eval_addr_q, eval_addr_d;  // address oam_data belongs to
  logic                     data_valid_q, data_valid_d; // oam_data is a scanned word
  logic [CNT_W-1:0]         hit_cnt_q, hit_cnt_d;
  buf_t                     buf_q, buf_d;
  logic                     ready_q, ready_d;

  logic [10:0] diff;
  logic        hit;

  // Sprite x and attribute bits do not take part in line selection.
  logic unused_inputs;
  assign unused_inputs = ^{sx, oam_data[31:10]};

  // 11-bit unsigned compare: the explicit >= check stops y near 1023 from
  // wrapping around and matching low lines.
  always_comb begin
    diff = {1'b0, line_q} - {1'b0, oam_data[9:0]};
    hit  = data_valid_q && (line_q >= oam_data[9:0]) && (diff < HEIGHT);
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    addr_d       = addr_q;
    eval_addr_d  = eval_addr_q;
    data_valid_d = data_valid_q;
    hit_cnt_d    = hit_cnt_q;
    buf_d        = buf_q;

    case (state_q)
      ST_START: begin
        line_d       = sy;
        buf_d        = '0;
        hit_cnt_d    = '0;
        addr_d       = '0;
        data_valid_d = 1'b0;
        state_d      = ST_SCAN;
      end

      ST_SCAN: begin
        // The word returned next cycle belongs to the address driven now.
        data_valid_d = 1'b1;
        eval_addr_d  = addr_q;
        if (addr_q != LAST_ADDR) begin
          addr_d = addr_q + ADDR_ONE;
        end

        if (hit) begin
          for (int j = 0; j < maxObjectPerLine; j++) begin
            if (hit_cnt_q == CNT_W'(j)) begin
              buf_d[j] = {eval_addr_q, 1'b1};
            end
          end
          hit_cnt_d = hit_cnt_q + CNT_ONE;
        end

        // Stop once the buffer is full or the last object has been judged;
        // the last write and the move to DONE share this cycle.
        if (data_valid_q && ((hit && (hit_cnt_q == LAST_SLOT)) ||
                             (eval_addr_q == LAST_ADDR))) begin
          state_d = ST_DONE;
          addr_d  = addr_q;
        end
      end

      ST_DONE: begin
        if (sy != line_q) begin
          state_d = ST_START;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase

    ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_START;
      line_q       <= '0;
      addr_q       <= '0;
      eval_addr_q  <= '0;
      data_valid_q <= 1'b0;
      hit_cnt_q    <= '0;
      buf_q        <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      eval_addr_q  <= eval_addr_d;
      data_valid_q <= data_valid_d;
      hit_cnt_q    <= hit_cnt_d;
      buf_q        <= buf_d;
      ready_q      <= ready_d;
    end
  end

  assign oam_addr       = addr_q;
  assign BufferArray    = buf_q;
  assign line_prepeared = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_prepare_scanline.sv
`default_nettype none
// ============================================================================
// Module  : tb_prepare_scanline
// Purpose : Self-checking bench for prepare_scanline. A table of directed
//           OAM/scanline setups with hand-computed buffers, followed by
//           hand-written sequences for line change and mid-scan reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prepare_scanline;

  localparam int MAXO = 32;
  localparam int AW   = 6;
  localparam int NOBJ = 64;

  typedef logic [MAXO-1:0][AW:0] buf_t;

  typedef struct {
    logic [9:0] sy;
    logic [9:0] y_def;
    logic       a31;
    int         o0;
    logic [9:0] y0;
    int         o1;
    logic [9:0] y1;
    int         o2;
    logic [9:0] y2;
    buf_t       exp;
    int         bound;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   oam_data;
  logic [9:0]    sx;
  logic [9:0]    sy;
  logic [AW-1:0] oam_addr;
  buf_t          buf_arr;
  logic          line_prepeared;

  logic [31:0] mem [NOBJ];

  int n_cmp = 0;
  int n_bad = 0;

  prepare_scanline #(
    .maxObjectPerLine(MAXO),
    .OAMMaxObjects   (256),
    .OAM_ADDR_SIZE   (AW),
    .OBJ_HEIGHT      (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .oam_data      (oam_data),
    .sx            (sx),
    .sy            (sy),
    .oam_addr      (oam_addr),
    .BufferArray   (buf_arr),
    .line_prepeared(line_prepeared)
  );

  always #5 clk = ~clk;

  // OAM model with one cycle read latency.
  always @(posedge clk) oam_data <= mem[oam_addr];

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic buf_t seq_buf();
    buf_t b;
    for (int i = 0; i < MAXO; i++) b[i] = {AW'(i), 1'b1};
    return b;
  endfunction

  function automatic buf_t lst(input int n, input int a, input int b, input int c);
    buf_t r;
    r = '0;
    if (n > 0) r[0] = {AW'(a), 1'b1};
    if (n > 1) r[1] = {AW'(b), 1'b1};
    if (n > 2) r[2] = {AW'(c), 1'b1};
    return r;
  endfunction

  function automatic vec_t mk(input logic [9:0] sy_i, input logic [9:0] ydef, input logic a31,
                              input int o0, input logic [9:0] y0,
                              input int o1, input logic [9:0] y1,
                              input int o2, input logic [9:0] y2,
                              input buf_t e, input int bound);
    vec_t v;
    v.sy = sy_i; v.y_def = ydef; v.a31 = a31;
    v.o0 = o0; v.y0 = y0; v.o1 = o1; v.y1 = y1; v.o2 = o2; v.y2 = y2;
    v.exp = e; v.bound = bound;
    return v;
  endfunction

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < NOBJ; i++) mem[i] = {v.a31, 11'd0, 10'(i), v.y_def};
    if (v.o0 >= 0) mem[v.o0][9:0] = v.y0;
    if (v.o1 >= 0) mem[v.o1][9:0] = v.y1;
    if (v.o2 >= 0) mem[v.o2][9:0] = v.y2;
  endtask

  // Bounded wait for line_prepeared; an expired bound shows up as a failed check.
  task automatic wait_done(input int bound, input string name);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (line_prepeared) break;
    end
    chk(name, 224'(line_prepeared), 224'(1));
  endtask

  task automatic start_vec(input vec_t v);
    @(negedge clk);
    reset = 1'b0;
    load_mem(v);
    sy = v.sy;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    reset = 1'b0;
    sx    = '0;
    sy    = '0;
    for (int i = 0; i < NOBJ; i++) mem[i] = '0;

    vecs[0] = mk(10'd0,   10'd0,   1'b0, -1, 0, -1, 0, -1, 0, seq_buf(), 42);
    vecs[1] = mk(10'd0,   10'd0,   1'b1, -1, 0, -1, 0, -1, 0, seq_buf(), 42);
    vecs[2] = mk(10'd100, 10'd0,   1'b0, -1, 0, -1, 0, -1, 0, '0, 74);
    vecs[3] = mk(10'd20,  10'd500, 1'b0, 3, 10'd10, 10, 10'd10, 63, 10'd10,
                 lst(3, 3, 10, 63), 74);
    vecs[4] = mk(10'd25,  10'd500, 1'b0, 5, 10'd10, 6, 10'd9, -1, 0, lst(1, 5, 0, 0), 74);
    vecs[5] = mk(10'd5,   10'd500, 1'b0, 0, 10'd1023, -1, 0, -1, 0, '0, 74);
    vecs[6] = mk(10'd515, 10'd500, 1'b0, -1, 0, -1, 0, -1, 0, seq_buf(), 42);
    vecs[7] = mk(10'd516, 10'd500, 1'b0, -1, 0, -1, 0, -1, 0, '0, 74);

    #1;
    chk("rst_ready", 224'(line_prepeared), 224'(0));
    chk("rst_addr",  224'(oam_addr),       224'(0));
    chk("rst_buf",   224'(buf_arr),        224'(0));

    for (int k = 0; k < 8; k++) begin
      start_vec(vecs[k]);
      wait_done(vecs[k].bound, $sformatf("vec%0d_done", k));
      chk($sformatf("vec%0d_buf", k), 224'(buf_arr), 224'(vecs[k].exp));
      @(negedge clk);
      chk($sformatf("vec%0d_hold", k), 224'({line_prepeared, buf_arr}),
          224'({1'b1, vecs[k].exp}));
    end

    // Line change in DONE, with a further change during the rescan ignored.
    start_vec(vecs[4]);
    wait_done(74, "chg_done0");
    sy = 10'd20;
    @(negedge clk);
    chk("chg_drop", 224'(line_prepeared), 224'(0));
    repeat (5) @(negedge clk);
    sy = 10'd25;
    wait_done(74, "chg_done1");
    chk("chg_buf20", 224'(buf_arr), 224'(lst(2, 5, 6, 0)));
    @(negedge clk);
    chk("chg_drop2", 224'(line_prepeared), 224'(0));
    wait_done(74, "chg_done2");
    chk("chg_buf25", 224'(buf_arr), 224'(lst(1, 5, 0, 0)));

    // Reset asserted in the middle of a scan.
    start_vec(vecs[0]);
    repeat (10) @(negedge clk);
    chk("mid_busy", 224'(line_prepeared), 224'(0));
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 224'(line_prepeared), 224'(0));
    chk("mid_rst_addr",  224'(oam_addr),       224'(0));
    chk("mid_rst_buf",   224'(buf_arr),        224'(0));
    @(negedge clk);
    reset = 1'b1;
    wait_done(42, "mid_done");
    chk("mid_buf", 224'(buf_arr), 224'(seq_buf()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
